regfile_vec_lanes: RTL and testbench
====================================

# regfile_vec_lanes

Parametrised vector register file for the SIMD datapath: a generalised successor to the fixed 128-bit vector file, with configurable register count, lane count and lane width. Adds per-lane write masking, a multi-cycle bulk-clear engine with busy indication, and optional write-to-read forwarding. Sits in the decode/execute boundary, serving two vector source operands and one vector writeback.

## Interface
- NUM_REGS, 16, number of vector registers (power of two, ≥2)
- LANES, 4, lanes per vector
- LANE_W, 32, bits per lane; vector width VW = LANES*LANE_W
- ADDR_W, 5, register address width
- VEC_BASE, 16, address of vector register 0 (0x10 => vrf0)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- vwe3  in  1  write enable
- vwa3  in  ADDR_W  write address
- vwd3  in  VW  write data, lane i = bits [i*LANE_W +: LANE_W]
- vwm3  in  LANES  per-lane write mask, 1 = lane written
- vra1, vra2  in  ADDR_W  read addresses
- vrd1, vrd2  out  VW  read data
- clr_req  in  1  request bulk clear of all registers
- busy  out  1  clear in progress

## Operation
- Address valid iff VEC_BASE ≤ addr < VEC_BASE+NUM_REGS; index = addr − VEC_BASE.
- Write: on edge with rst=1, vwe3=1, valid vwa3, busy=0 → lanes with vwm3[i]=1 take vwd3 lane i; other lanes unchanged. Invalid address or vwm3=0 → no change.
- Read: combinational; invalid address → all zeros.
- Clear FSM states IDLE, CLEAR; counter width $clog2(NUM_REGS).
  - IDLE: clr_req=1 → CLEAR, counter=0. Port write in same cycle still performed.
  - CLEAR: register[counter] zeroed each cycle, counter+1; after index NUM_REGS−1 → IDLE.
  - clr_req ignored while in CLEAR; port writes ignored while busy=1 (no queuing).
- Reads during CLEAR return current contents (already-cleared registers read 0).

## Timing
- Reset (rst=0 at edge): all registers 0, state IDLE, counter 0, busy 0; vrd1/vrd2 then read 0 for any address. Reset mid-clear aborts clear; next cycle IDLE.
- Write latency: data visible on read ports the cycle after the write edge (without forwarding).
- busy is registered: high the cycle after clr_req accepted, high for exactly NUM_REGS cycles, then low; new clr_req accepted on first cycle busy=0.
- vra1 = vra2 = same register: both ports return identical data.

## Configuration
- REGFILE_VEC_BYPASS_EN defined: when vwe3=1, busy=0, vwa3 valid and equal to vraN, vrdN lanes with vwm3[i]=1 return vwd3 lane i in the same cycle; unmasked lanes return stored value. Forwarding is combinational from write inputs.
- Undefined: no forwarding; reads always return stored contents.

## Structure
- Package regfile_vec_pkg: state enum (IDLE, CLEAR), default parameter constants, address-valid/index helper function.
- Sub-module regfile_vec_clear_fsm: state, counter, busy, and per-cycle clear index/enable output; storage and read mux stay in the top.

## Test plan
- Reset then read vra1=0x10, vra2=0x1F → both 0; busy=0.
- vwe3=1, vwa3=0x10, vwd3={16{8'hAA}}, vwm3=4'hF → next cycle vra1=0x10 reads 128'hAA..AA; vra2=0x11 reads 0.
- Then write 0x10 with vwd3={16{8'h55}}, vwm3=4'b0101 → reads 0xAAAAAAAA_55555555_AAAAAAAA_55555555.
- Write to 0x05 and to 0x20 with vwm3=4'hF → no register changes; read 0x05 → 0.
- Fill all 16 registers with nonzero data, pulse clr_req 1 cycle → busy high exactly 16 cycles; write to 0x12 during busy ignored; after busy low all reads 0.
- With REGFILE_VEC_BYPASS_EN: vwe3=1, vwa3=vra1=0x13, vwm3=4'b0011, vwd3 lanes=0x11111111 → vrd1 lanes 1:0 = 0x11111111 same cycle, lanes 3:2 old value; without macro vrd1 shows old value until next cycle.

Source files
------------

// File: rtl/regfile_vec_pkg.sv
// -----------------------------------------------------------------------------
// regfile_vec_pkg
// Shared definitions for the parametrised vector register file:
//   - clr_state_e  : bulk-clear engine states (IDLE, CLEAR)
//   - DEF_*        : default parameter values for the register file
//   - addr_valid   : true when an address falls inside the vector window
//   - addr_index   : register index for an address inside the window
// Optional feature macro used by the register file: REGFILE_VEC_BYPASS_EN.
// -----------------------------------------------------------------------------
package regfile_vec_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_LANES    = 4;
    localparam int DEF_LANE_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_VEC_BASE = 16;

    function automatic logic addr_valid(input int unsigned addr,
                                        input int unsigned base,
                                        input int unsigned num);
        return (addr >= base) && (addr < (base + num));
    endfunction

    function automatic int unsigned addr_index(input int unsigned addr,
                                               input int unsigned base);
        return addr - base;
    endfunction

endpackage

// File: rtl/regfile_vec_lanes_clear_fsm.sv
// -----------------------------------------------------------------------------
// regfile_vec_clear_fsm
// Bulk-clear sequencer. Once a request is accepted in IDLE, it walks every
// register index, one per cycle, then returns to IDLE. Requests arriving
// while a clear is running are dropped.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-low reset (aborts a running clear)
//   clr_req  in   request a bulk clear
//   busy     out  clear in progress (decoded from the state register)
//   clr_en   out  zero register clr_idx at the coming edge
//   clr_idx  out  register index being cleared this cycle
// -----------------------------------------------------------------------------
module regfile_vec_clear_fsm
    import regfile_vec_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int CNT_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_en,
    output logic [CNT_W-1:0] clr_idx
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_REGS - 1);

    clr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy    = (state_q == CLEAR);
    assign clr_en  = (state_q == CLEAR);
    assign clr_idx = cnt_q;

endmodule

// File: rtl/regfile_vec_lanes.sv
// -----------------------------------------------------------------------------
// regfile_vec_lanes
// Parametrised SIMD vector register file: two combinational read ports, one
// lane-masked write port, and a multi-cycle bulk-clear engine.
// Registers occupy addresses VEC_BASE .. VEC_BASE+NUM_REGS-1; anything else
// reads as zero and ignores writes.
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-low reset
//   vwe3        in   write enable
//   vwa3        in   write address
//   vwd3        in   write data, lane i = bits [i*LANE_W +: LANE_W]
//   vwm3        in   per-lane write mask, 1 = lane written
//   vra1, vra2  in   read addresses
//   vrd1, vrd2  out  read data
//   clr_req     in   request bulk clear of all registers
//   busy        out  clear in progress; port writes are dropped while high
// Optional feature: define REGFILE_VEC_BYPASS_EN to forward write-port lanes
// combinationally to a read port addressing the register being written.
// -----------------------------------------------------------------------------
module regfile_vec_lanes
    import regfile_vec_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int LANES    = DEF_LANES,
    parameter  int LANE_W   = DEF_LANE_W,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  int VEC_BASE = DEF_VEC_BASE,
    localparam int VW       = LANES * LANE_W,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vwe3,
    input  logic [ADDR_W-1:0] vwa3,
    input  logic [VW-1:0]     vwd3,
    input  logic [LANES-1:0]  vwm3,
    input  logic [ADDR_W-1:0] vra1,
    input  logic [ADDR_W-1:0] vra2,
    output logic [VW-1:0]     vrd1,
    output logic [VW-1:0]     vrd2,
    input  logic              clr_req,
    output logic              busy
);

    logic [VW-1:0]    regs_q [NUM_REGS];
    logic [VW-1:0]    regs_d [NUM_REGS];
    logic             clr_en;
    logic [IDX_W-1:0] clr_idx;

    logic             wr_valid, rd1_valid, rd2_valid;
    logic [IDX_W-1:0] wr_idx, rd1_idx, rd2_idx;

    regfile_vec_clear_fsm #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    assign wr_valid  = addr_valid(32'(vwa3), VEC_BASE, NUM_REGS);
    assign rd1_valid = addr_valid(32'(vra1), VEC_BASE, NUM_REGS);
    assign rd2_valid = addr_valid(32'(vra2), VEC_BASE, NUM_REGS);
    assign wr_idx    = IDX_W'(addr_index(32'(vwa3), VEC_BASE));
    assign rd1_idx   = IDX_W'(addr_index(32'(vra1), VEC_BASE));
    assign rd2_idx   = IDX_W'(addr_index(32'(vra2), VEC_BASE));

    // clr_en is high exactly while busy, so the clear takes priority and the
    // port write is dropped rather than queued.
    always_comb begin
        regs_d = regs_q;
        if (clr_en) begin
            regs_d[clr_idx] = '0;
        end else if (vwe3 && wr_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (vwm3[i]) begin
                    regs_d[wr_idx][i*LANE_W +: LANE_W] = vwd3[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_VEC_BYPASS_EN
    logic fwd_ok, fwd1, fwd2;
    assign fwd_ok = vwe3 && !busy && wr_valid;
    assign fwd1   = fwd_ok && (vra1 == vwa3);
    assign fwd2   = fwd_ok && (vra2 == vwa3);
`endif

    always_comb begin
        vrd1 = rd1_valid ? regs_q[rd1_idx] : '0;
        vrd2 = rd2_valid ? regs_q[rd2_idx] : '0;
`ifdef REGFILE_VEC_BYPASS_EN
        // Only masked lanes are forwarded; the rest still come from storage.
        for (int i = 0; i < LANES; i++) begin
            if (fwd1 && vwm3[i]) vrd1[i*LANE_W +: LANE_W] = vwd3[i*LANE_W +: LANE_W];
            if (fwd2 && vwm3[i]) vrd2[i*LANE_W +: LANE_W] = vwd3[i*LANE_W +: LANE_W];
        end
`endif
    end

endmodule

// File: tb/tb_regfile_vec_lanes.sv
module tb_regfile_vec_lanes;

    localparam int NR   = 16;
    localparam int LN   = 4;
    localparam int LW   = 32;
    localparam int AW   = 5;
    localparam int BASE = 16;
    localparam int VW   = LN * LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          vwe3;
    logic [AW-1:0] vwa3;
    logic [VW-1:0] vwd3;
    logic [LN-1:0] vwm3;
    logic [AW-1:0] vra1, vra2;
    logic [VW-1:0] vrd1, vrd2;
    logic          clr_req;
    logic          busy;

    always #5 clk = ~clk;

    regfile_vec_lanes #(
        .NUM_REGS (NR),
        .LANES    (LN),
        .LANE_W   (LW),
        .ADDR_W   (AW),
        .VEC_BASE (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .vwe3    (vwe3),
        .vwa3    (vwa3),
        .vwd3    (vwd3),
        .vwm3    (vwm3),
        .vra1    (vra1),
        .vra2    (vra2),
        .vrd1    (vrd1),
        .vrd2    (vrd2),
        .clr_req (clr_req),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus the number of clear cycles left.
    logic [VW-1:0] mem [NR];
    int            clr_left = 0;

    function automatic logic in_win(input int a);
        return (a >= BASE) && (a < BASE + NR);
    endfunction

    function automatic logic [VW-1:0] exp_rd(input int a);
        logic [VW-1:0] v;
        v = in_win(a) ? mem[a-BASE] : '0;
`ifdef REGFILE_VEC_BYPASS_EN
        if (vwe3 && clr_left == 0 && in_win(int'(vwa3)) && int'(vwa3) == a) begin
            for (int i = 0; i < LN; i++)
                if (vwm3[i]) v[i*LW +: LW] = vwd3[i*LW +: LW];
        end
`endif
        return v;
    endfunction

    task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk_vec("vrd1", vrd1, exp_rd(int'(vra1)));
        chk_vec("vrd2", vrd2, exp_rd(int'(vra2)));
        chk_int("busy", int'(busy), (clr_left > 0) ? 1 : 0);
    endtask

    task automatic model_edge();
        if (!rst) begin
            for (int r = 0; r < NR; r++) mem[r] = '0;
            clr_left = 0;
        end else if (clr_left > 0) begin
            mem[NR-clr_left] = '0;
            clr_left--;
        end else begin
            if (vwe3 && in_win(int'(vwa3))) begin
                for (int i = 0; i < LN; i++)
                    if (vwm3[i]) mem[int'(vwa3)-BASE][i*LW +: LW] = vwd3[i*LW +: LW];
            end
            if (clr_req) clr_left = NR;
        end
    endtask

    // One clock: compare on the falling edge, advance the model on the rising
    // edge, then return just after the edge so the caller can drive inputs.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input int a, input logic [VW-1:0] d, input logic [LN-1:0] m);
        vwe3 = 1'b1;
        vwa3 = AW'(a);
        vwd3 = d;
        vwm3 = m;
        cyc();
        vwe3 = 1'b0;
    endtask

    function automatic logic [VW-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int busy_cnt;

    initial begin
        rst     = 1'b0;
        vwe3    = 1'b0;
        vwa3    = '0;
        vwd3    = '0;
        vwm3    = '0;
        vra1    = '0;
        vra2    = '0;
        clr_req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            model_edge();
            #1;
        end
        rst = 1'b1;

        // Reset state
        vra1 = AW'(5'h10);
        vra2 = AW'(5'h1F);
        #1;
        chk_vec("rst_rd1", vrd1, '0);
        chk_vec("rst_rd2", vrd2, '0);
        chk_int("rst_busy", int'(busy), 0);
        cyc();

        // Full-mask write
        wr(16'h10, {16{8'hAA}}, 4'hF);
        vra1 = AW'(5'h10);
        vra2 = AW'(5'h11);
        #1;
        chk_vec("full_wr", vrd1, {16{8'hAA}});
        chk_vec("neighbour", vrd2, '0);
        cyc();

        // Partial-mask write: lanes 0 and 2
        wr(16'h10, {16{8'h55}}, 4'b0101);
        #1;
        chk_vec("mask_wr", vrd1, 128'hAAAAAAAA_55555555_AAAAAAAA_55555555);
        cyc();

        // Out-of-window writes change nothing
        wr(16'h05, rnd_vec(), 4'hF);
        wr(16'h00, rnd_vec(), 4'hF);
        wr(16'h0F, rnd_vec(), 4'hF);
        vra1 = AW'(5'h05);
        #1;
        chk_vec("oow_rd", vrd1, '0);
        for (int a = 0; a < 32; a++) begin
            vra1 = AW'(a);
            vra2 = AW'(31 - a);
            cyc();
        end

        // Fill, then bulk clear with a write attempted throughout busy
        for (int r = 0; r < NR; r++) wr(BASE + r, rnd_vec() | 128'h1, 4'hF);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        vwe3 = 1'b1;
        vwa3 = AW'(5'h12);
        vwd3 = '1;
        vwm3 = 4'hF;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            else if (busy_cnt > 0) break;
            cyc();
        end
        vwe3 = 1'b0;
        chk_int("busy_len", busy_cnt, NR);
        for (int r = 0; r < NR; r++) begin
            vra1 = AW'(BASE + r);
            #1;
            chk_vec("clr_rd", vrd1, '0);
            cyc();
        end

        // Same-cycle forwarding
        wr(16'h13, {4{32'hCAFEBABE}}, 4'hF);
        vwe3 = 1'b1;
        vwa3 = AW'(5'h13);
        vra1 = AW'(5'h13);
        vwm3 = 4'b0011;
        vwd3 = {4{32'h11111111}};
        #1;
`ifdef REGFILE_VEC_BYPASS_EN
        chk_vec("fwd_same", vrd1, {32'hCAFEBABE, 32'hCAFEBABE, 32'h11111111, 32'h11111111});
`else
        chk_vec("fwd_same", vrd1, {4{32'hCAFEBABE}});
`endif
        cyc();
        vwe3 = 1'b0;
        #1;
        chk_vec("fwd_next", vrd1, {32'hCAFEBABE, 32'hCAFEBABE, 32'h11111111, 32'h11111111});
        cyc();

        // Reset in the middle of a clear
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (5) cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk_int("rst_abort", int'(busy), 0);
        cyc();

        // Randomized traffic
        for (int n = 0; n < 1000; n++) begin
            rst     = ($urandom_range(0, 149) != 0);
            clr_req = ($urandom_range(0, 29) == 0);
            vwe3    = $urandom_range(0, 1) == 1;
            vwa3    = AW'($urandom_range(0, 31));
            vwd3    = rnd_vec();
            vwm3    = LN'($urandom);
            vra1    = ($urandom_range(0, 2) == 0) ? vwa3 : AW'($urandom_range(0, 31));
            vra2    = ($urandom_range(0, 2) == 0) ? vwa3 : AW'($urandom_range(0, 31));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
